uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Buffered 8N1 UART transmitter that drives the board's serial TX pin from the machine's peripheral side. The machine pushes bytes into a DEPTH-entry FIFO with a single-cycle write strobe. The block serialises them at a fixed clock divider, back to back, so the CPU never stalls on a single outstanding byte. It sits directly between the machine core and the uart_tx top-level pin.

Parameters:
CLK_DIV, 104, clock cycles per UART bit (12 MHz / 115200 ≈ 104); legal range ≥ 2.
DEPTH, 16, FIFO entries; power of two, ≥ 2.

Ports:
clk  input  1  system clock (machine clock domain)
rst  input  1  asynchronous, active-high reset
wr_en  input  1  push strobe, one byte per cycle
wr_data  input  8  byte to push
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
overflow  output  1  sticky: a push was dropped because FIFO was full
busy  output  1  high while FIFO non-empty or a frame is in flight
tx  output  1  serial line, idle high, registered

Behaviour:
- Reset (async, active-high; all flops): tx=1, state=IDLE, FIFO pointers=0, count=0, empty=1, full=0, overflow=0, busy=0.
- Reset mid-frame: tx returns to 1 immediately and the frame is truncated. FIFO contents are discarded.
- full, empty and count are registered, and update on the edge after the push or pop that changes them.
- Push accepted on an edge where wr_en=1 and full=0 (full as seen before the edge). Data is stored at the write pointer; the pointer wraps modulo DEPTH.
- Push with full=1: byte dropped, FIFO unchanged, overflow<=1. overflow stays set until rst.
- Pop is internal only, performed by the FSM.
- Simultaneous push and pop: both take effect and count is unchanged. When full, a same-cycle pop does not make room for the push; full is sampled pre-edge, so the push is dropped.
- No bypass: a byte pushed into an empty FIFO is popped at the earliest on the following edge.
- Baud counter: bit_cnt counts 0..CLK_DIV-1. Each serial bit is held exactly CLK_DIV cycles.
- FSM states and transitions:
  - IDLE: tx=1. If empty=0: pop head into the shift register, reset baud counter, go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first), held CLK_DIV cycles per bit. Shift right after each bit. After bit index 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. On the last stop cycle: if empty=0, pop and go directly to START (no idle gap); else go to IDLE.
- tx is a registered output. The first start-bit cycle appears on the edge following the pop.
- Frame length is exactly 10*CLK_DIV cycles. Back-to-back frames have period exactly 10*CLK_DIV.
- busy = (state != IDLE) | ~empty, registered or combinational from registers. It deasserts only once the last stop bit has completed and the FIFO is empty.
- Pushes during transmission never disturb the frame in flight.

Test Plan:
- Reset state: assert rst mid-sim -> tx=1, count=0, empty=1, full=0, overflow=0, busy=0 immediately, with no dependence on clk.
- Single byte (CLK_DIV=4): push 0xA5 -> tx sequence start 0, then bits 1,0,1,0,0,1,0,1, then stop 1. Each bit is 4 cycles (40 cycles total); busy then drops and count returns to 0.
- Back-to-back: push 0x00, 0xFF, 0x55 on consecutive cycles -> three frames with no idle gap. The falling edge of each start bit is exactly 40 cycles apart; count peaks at 3 (or 2 once the first pop occurs) and ends at 0.
- Full/overflow (DEPTH=4, CLK_DIV=4): push 6 bytes 0x01..0x06 on consecutive cycles.
  - The first pop frees one slot, so 5 bytes are accepted and 0x06 is dropped.
  - full=1 is observed, overflow=1 and stays 1.
  - Serialised order is 0x01..0x05.
- Simultaneous push/pop: keep the FIFO at count=2 and push on the same edge the FSM pops -> count stays 2 and no byte is lost or duplicated. A scoreboard compares the byte stream decoded from tx against the accepted pushes.
- Reset mid-frame: push 0x3C, assert rst during DATA bit 3, release, then push 0x81 -> tx is 1 throughout reset. The next frame is a clean 0x81 with no remnant of 0x3C.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: DEPTH-entry byte FIFO feeding a fixed-divider serialiser.
// IDLE | line high, waiting for data   START | start bit   DATA | 8 bits LSB first   STOP | stop bit
module uart_tx_fifo #(
    parameter int CLK_DIV = 104,
    parameter int DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     busy,
    output logic                     tx
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, overflow_q;
    logic          push, pop;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          baud_end;

    // full is the pre-edge value, so a same-cycle pop never makes room for a push
    assign push     = wr_en & ~full_q;
    assign baud_end = (baud_q == BW'(CLK_DIV - 1));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wr_data;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (wr_en && full_q) begin
                overflow_q <= 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // tx follows the next state so the line is registered with no extra cycle of latency
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) | ~empty_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a line decoder that recovers bytes and start-bit times from tx.
module tb_uart_tx_fifo;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty, overflow, busy, tx;
    logic [2:0] count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .busy(busy), .tx(tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples mid-bit on negedges, aborts on reset.
    logic [7:0] rx_q [$];
    int         fall_q [$];
    int         frame_err = 0;
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;

    always @(negedge clk) begin
        int n;
        n = mon_cnt + 1;
        if (rst === 1'b1) begin
            mon_active <= 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active <= 1'b1;
                mon_cnt    <= 0;
                fall_q.push_back(cyc);
            end
        end else begin
            mon_cnt <= n;
            if (n == 2 && tx !== 1'b0) frame_err <= frame_err + 1;
            if (n >= 6 && n <= 34 && (n % 4) == 2) mon_byte[(n - 6) / 4] <= tx;
            if (n == 38) begin
                if (tx !== 1'b1) frame_err <= frame_err + 1;
                rx_q.push_back(mon_byte);
                mon_active <= 1'b0;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok, output int peak);
        ok   = 1'b0;
        peak = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
            if (busy === 1'b0 && !mon_active) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        #1 rst = 1'b1;
        #1;
        total_cnt++; if (tx !== 1'b1) $display("FAIL rst_tx: got %b want 1", tx); else pass_cnt++;
        total_cnt++; if (count !== 3'd0) $display("FAIL rst_count: got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else pass_cnt++;
        total_cnt++; if (full !== 1'b0) $display("FAIL rst_full: got %b want 0", full); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] b;
        logic       exp_bit;
        logic [2:0] c0;
        logic       busy39;
        int         errs, rb, e0;
        b = 8'hA5; errs = 0; rb = rx_q.size(); e0 = frame_err;
        @(negedge clk);
        push(b);
        total_cnt++; if (tx !== 1'b1) $display("FAIL single_nobypass_tx: got %b want 1", tx); else pass_cnt++;
        total_cnt++; if (count !== 3'd1) $display("FAIL single_count1: got %0d want 1", count); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else pass_cnt++;
        c0 = 3'd7; busy39 = 1'b0;
        for (int i = 0; i < 10 * CLK_DIV; i++) begin
            @(negedge clk);
            if (i < 4) exp_bit = 1'b0;
            else if (i < 36) exp_bit = b[(i - 4) / 4];
            else exp_bit = 1'b1;
            if (tx !== exp_bit) errs++;
            if (i == 0) c0 = count;
            if (i == 39) busy39 = busy;
        end
        total_cnt++; if (errs != 0) $display("FAIL single_waveform: got %0d bad cycles want 0", errs); else pass_cnt++;
        total_cnt++; if (c0 !== 3'd0) $display("FAIL single_popped: got %0d want 0", c0); else pass_cnt++;
        total_cnt++; if (busy39 !== 1'b1) $display("FAIL single_busy_last_stop: got %b want 1", busy39); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL single_busy_drop: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (rx_q.size() != rb + 1 || rx_q[rb] !== 8'hA5)
            $display("FAIL single_byte: got %0d bytes want 1 of a5", rx_q.size() - rb); else pass_cnt++;
        total_cnt++; if (frame_err != e0) $display("FAIL single_framing: got %0d errors want 0", frame_err - e0); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        bit ok; int peak, rb, fb, e0, bad;
        exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55;
        rb = rx_q.size(); fb = fall_q.size(); e0 = frame_err; bad = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) push(exp[i]);
        wait_idle(300, ok, peak);
        total_cnt++; if (!ok) $display("FAIL b2b_timeout: got busy want idle within 300 cycles"); else pass_cnt++;
        total_cnt++; if (peak != 2) $display("FAIL b2b_peak_count: got %0d want 2", peak); else pass_cnt++;
        if (rx_q.size() != rb + 3) bad++;
        else for (int i = 0; i < 3; i++) if (rx_q[rb + i] !== exp[i]) bad++;
        total_cnt++; if (bad != 0) $display("FAIL b2b_bytes: got %0d wrong (%0d bytes) want 0", bad, rx_q.size() - rb); else pass_cnt++;
        bad = 0;
        if (fall_q.size() != fb + 3) bad++;
        else for (int i = 1; i < 3; i++) if (fall_q[fb + i] - fall_q[fb + i - 1] != 40) bad++;
        total_cnt++; if (bad != 0) $display("FAIL b2b_period: got %0d bad gaps want 0 (each 40)", bad); else pass_cnt++;
        total_cnt++; if (count !== 3'd0) $display("FAIL b2b_count_end: got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (frame_err != e0) $display("FAIL b2b_framing: got %0d errors want 0", frame_err - e0); else pass_cnt++;
    endtask

    task automatic test_overflow();
        bit ok; int peak, rb, bad;
        rb = rx_q.size(); bad = 0;
        @(negedge clk);
        for (int i = 1; i <= 6; i++) push(8'(i));
        total_cnt++; if (full !== 1'b1) $display("FAIL ovf_full: got %b want 1", full); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else pass_cnt++;
        total_cnt++; if (count !== 3'd4) $display("FAIL ovf_count: got %0d want 4", count); else pass_cnt++;
        wait_idle(400, ok, peak);
        total_cnt++; if (!ok) $display("FAIL ovf_timeout: got busy want idle within 400 cycles"); else pass_cnt++;
        if (rx_q.size() != rb + 5) bad++;
        else for (int i = 0; i < 5; i++) if (rx_q[rb + i] !== 8'(i + 1)) bad++;
        total_cnt++; if (bad != 0) $display("FAIL ovf_order: got %0d wrong (%0d bytes) want 0 of 01..05", bad, rx_q.size() - rb); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else pass_cnt++;
        total_cnt++; if (full !== 1'b0 || empty !== 1'b1) $display("FAIL ovf_drain: got full=%b empty=%b want 0 1", full, empty); else pass_cnt++;
    endtask

    task automatic test_simul();
        logic [7:0] exp [6];
        bit ok; int peak, rb, fb, e0, bad, k, g;
        exp[0] = 8'h10; exp[1] = 8'h11; exp[2] = 8'h12;
        exp[3] = 8'h20; exp[4] = 8'h21; exp[5] = 8'h22;
        rb = rx_q.size(); fb = fall_q.size(); e0 = frame_err; bad = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) push(exp[i]);
        total_cnt++; if (count !== 3'd2) $display("FAIL simul_prefill: got %0d want 2", count); else pass_cnt++;
        k = (fall_q.size() > fb) ? fall_q[fb] : cyc;
        for (int j = 0; j < 3; j++) begin
            g = 0;
            while (cyc < k + 39 + 40 * j && g < 1000) begin
                @(negedge clk);
                g++;
            end
            wr_en = 1'b1; wr_data = exp[3 + j];
            @(negedge clk);
            wr_en = 1'b0;
            total_cnt++; if (count !== 3'd2) $display("FAIL simul_count_%0d: got %0d want 2", j, count); else pass_cnt++;
        end
        wait_idle(600, ok, peak);
        total_cnt++; if (!ok) $display("FAIL simul_timeout: got busy want idle within 600 cycles"); else pass_cnt++;
        if (rx_q.size() != rb + 6) bad++;
        else for (int i = 0; i < 6; i++) if (rx_q[rb + i] !== exp[i]) bad++;
        total_cnt++; if (bad != 0) $display("FAIL simul_stream: got %0d wrong (%0d bytes) want 0", bad, rx_q.size() - rb); else pass_cnt++;
        total_cnt++; if (frame_err != e0) $display("FAIL simul_framing: got %0d errors want 0", frame_err - e0); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        bit ok; int peak, rb, fb, e0, g, k, errs;
        rb = rx_q.size(); fb = fall_q.size(); e0 = frame_err; errs = 0;
        @(negedge clk);
        push(8'h3C);
        g = 0;
        while (fall_q.size() <= fb && g < 100) begin
            @(negedge clk);
            g++;
        end
        total_cnt++; if (fall_q.size() <= fb) $display("FAIL rm_start: got no start bit want one within 100 cycles"); else pass_cnt++;
        k = (fall_q.size() > fb) ? fall_q[fb] : cyc;
        g = 0;
        while (cyc < k + 17 && g < 100) begin
            @(negedge clk);
            g++;
        end
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (tx !== 1'b1) $display("FAIL rm_tx: got %b want 1", tx); else pass_cnt++;
        total_cnt++; if (count !== 3'd0) $display("FAIL rm_count: got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL rm_flags: got empty=%b full=%b want 1 0", empty, full); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL rm_overflow: got %b want 0", overflow); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else pass_cnt++;
        repeat (3) begin
            @(negedge clk);
            if (tx !== 1'b1) errs++;
        end
        total_cnt++; if (errs != 0) $display("FAIL rm_tx_held: got %0d low cycles want 0", errs); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        push(8'h81);
        wait_idle(200, ok, peak);
        total_cnt++; if (!ok) $display("FAIL rm_timeout: got busy want idle within 200 cycles"); else pass_cnt++;
        total_cnt++; if (rx_q.size() != rb + 1 || rx_q[rb] !== 8'h81)
            $display("FAIL rm_clean_frame: got %0d bytes want exactly one 81", rx_q.size() - rb); else pass_cnt++;
        total_cnt++; if (frame_err != e0) $display("FAIL rm_framing: got %0d errors want 0", frame_err - e0); else pass_cnt++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_simul();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
